bbox_msg_reader: RTL and testbench

Avalon-MM master that drains bounding-box messages from the image-processor message port. It polls the status register, reads three-word messages (ID, min corner, max corner) from the message register one word at a time, validates the ID, and presents decoded boxes on a valid/ready stream to downstream control logic such as the rover steering FSM. It replaces software polling by the soft CPU for latency-critical box tracking.

---
 rtl/bbox_msg_pkg.sv | 40 ++++
 rtl/bbox_msg_reader.sv | 201 ++++++++++++++++++++
 tb/tb_bbox_msg_reader.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bbox_msg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bbox_msg_pkg
// Brief    : Shared constants, FSM state encoding and box type for the
//            bounding-box message reader.
// Revision : 1.0 - initial release
// ============================================================================
package bbox_msg_pkg;

    localparam logic [2:0]  c_ADDR_STATUS = 3'd0;
    localparam logic [2:0]  c_ADDR_MSG    = 3'd1;
    localparam logic [2:0]  c_ADDR_ID     = 3'd2;
    localparam logic [2:0]  c_ADDR_BBCOL  = 3'd3;

    localparam logic [31:0] c_RBB_MSG_ID  = 32'h0052_4242;
    localparam int          c_FLUSH_BIT   = 4;

    typedef enum logic [3:0] {
        ST_POLL      = 4'd0,
        ST_POLL_WAIT = 4'd1,
        ST_HDR       = 4'd2,
        ST_HDR_WAIT  = 4'd3,
        ST_W1        = 4'd4,
        ST_W1_WAIT   = 4'd5,
        ST_W2        = 4'd6,
        ST_W2_WAIT   = 4'd7,
        ST_EMIT      = 4'd8,
        ST_IDLE_WAIT = 4'd9,
        ST_FLUSH     = 4'd10
    } state_t;

    typedef struct packed {
        logic [10:0] x_min;
        logic [10:0] y_min;
        logic [10:0] x_max;
        logic [10:0] y_max;
    } bbox_t;

endpackage
`default_nettype wire

// File: rtl/bbox_msg_reader.sv
`default_nettype none
// ============================================================================
// Module   : bbox_msg_reader
// Brief    : Avalon-MM master that polls the image-processor message port,
//            reads 3-word bounding-box messages and streams decoded boxes.
//            Optional macro BBOX_READER_FLUSH_EN: flush the slave FIFO on a
//            header mismatch instead of reading onward.
// Revision : 1.0 - initial release
// ============================================================================
module bbox_msg_reader
    import bbox_msg_pkg::*;
#(
    parameter int          POLL_INTERVAL = 1024,
    parameter int          READ_LATENCY  = 1,
    parameter logic [31:0] MSG_ID        = c_RBB_MSG_ID
) (
    input  logic        clk,
    input  logic        reset,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] out_x_min,
    output logic [10:0] out_y_min,
    output logic [10:0] out_x_max,
    output logic [10:0] out_y_max,
    output logic [7:0]  sync_err_count
);

    localparam int c_CNT_MAX = (POLL_INTERVAL > READ_LATENCY) ? POLL_INTERVAL : READ_LATENCY;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_IDLE_LOAD = c_CNT_W'(POLL_INTERVAL - 1);
    localparam logic [c_CNT_W-1:0] c_LAT_LOAD  = c_CNT_W'(READ_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    bbox_t                r_box;
    logic                 r_cs;
    logic                 r_read;
    logic [2:0]           r_addr;
    logic                 r_valid;
    logic [7:0]           r_err;
    logic                 w_cnt_done;

    assign w_cnt_done = (r_cnt == '0);

`ifdef BBOX_READER_FLUSH_EN
    logic                 r_write;
    logic [31:0]          r_wdata;
    assign m_write     = r_write;
    assign m_writedata = r_wdata;
`else
    assign m_write     = 1'b0;
    assign m_writedata = '0;
`endif

    assign m_chipselect   = r_cs;
    assign m_read         = r_read;
    assign m_address      = r_addr;
    assign out_valid      = r_valid;
    assign out_x_min      = r_box.x_min;
    assign out_y_min      = r_box.y_min;
    assign out_x_max      = r_box.x_max;
    assign out_y_max      = r_box.y_max;
    assign sync_err_count = r_err;

    // Bus outputs are loaded on entry to each read state, so the pulse lines
    // up with the state itself; every wait state drops the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_POLL;
            r_cnt   <= '0;
            r_box   <= '0;
            r_cs    <= 1'b0;
            r_read  <= 1'b0;
            r_addr  <= c_ADDR_STATUS;
            r_valid <= 1'b0;
            r_err   <= 8'd0;
`ifdef BBOX_READER_FLUSH_EN
            r_write <= 1'b0;
            r_wdata <= 32'd0;
`endif
        end else begin
            r_cs   <= 1'b0;
            r_read <= 1'b0;
`ifdef BBOX_READER_FLUSH_EN
            r_write <= 1'b0;
`endif
            unique case (r_state)
                ST_POLL: begin
                    if (r_read) begin
                        r_state <= ST_POLL_WAIT;
                        r_cnt   <= c_LAT_LOAD;
                    end else begin
                        // Only reachable straight out of reset: arm the poll.
                        r_cs   <= 1'b1;
                        r_read <= 1'b1;
                        r_addr <= c_ADDR_STATUS;
                    end
                end
                ST_POLL_WAIT: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else if (m_readdata[15:8] >= 8'd3) begin
                        r_state <= ST_HDR;
                        r_cs    <= 1'b1;
                        r_read  <= 1'b1;
                        r_addr  <= c_ADDR_MSG;
                    end else begin
                        r_state <= ST_IDLE_WAIT;
                        r_cnt   <= c_IDLE_LOAD;
                    end
                end
                ST_HDR, ST_W1, ST_W2: begin
                    r_state <= state_t'(r_state + 4'd1);
                    r_cnt   <= c_LAT_LOAD;
                end
                ST_HDR_WAIT: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else if (m_readdata == MSG_ID) begin
                        r_state <= ST_W1;
                        r_cs    <= 1'b1;
                        r_read  <= 1'b1;
                        r_addr  <= c_ADDR_MSG;
                    end else begin
                        if (r_err != 8'hFF) begin
                            r_err <= r_err + 8'd1;
                        end
`ifdef BBOX_READER_FLUSH_EN
                        r_state <= ST_FLUSH;
                        r_cs    <= 1'b1;
                        r_write <= 1'b1;
                        r_addr  <= c_ADDR_STATUS;
                        r_wdata <= 32'd1 << c_FLUSH_BIT;
`else
                        r_state <= ST_POLL;
                        r_cs    <= 1'b1;
                        r_read  <= 1'b1;
                        r_addr  <= c_ADDR_STATUS;
`endif
                    end
                end
                ST_W1_WAIT: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else begin
                        r_box.x_min <= m_readdata[26:16];
                        r_box.y_min <= m_readdata[10:0];
                        r_state     <= ST_W2;
                        r_cs        <= 1'b1;
                        r_read      <= 1'b1;
                        r_addr      <= c_ADDR_MSG;
                    end
                end
                ST_W2_WAIT: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else begin
                        r_box.x_max <= m_readdata[26:16];
                        r_box.y_max <= m_readdata[10:0];
                        r_valid     <= 1'b1;
                        r_state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_POLL;
                        r_cs    <= 1'b1;
                        r_read  <= 1'b1;
                        r_addr  <= c_ADDR_STATUS;
                    end
                end
                ST_IDLE_WAIT: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else begin
                        r_state <= ST_POLL;
                        r_cs    <= 1'b1;
                        r_read  <= 1'b1;
                        r_addr  <= c_ADDR_STATUS;
                    end
                end
                default: begin
                    r_state <= ST_POLL;
                    r_cs    <= 1'b1;
                    r_read  <= 1'b1;
                    r_addr  <= c_ADDR_STATUS;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bbox_msg_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bbox_msg_reader
// Brief    : Self-checking bench for bbox_msg_reader: message-port slave with a
//            word FIFO, stream-level box/error model, directed and random runs.
//            Honours BBOX_READER_FLUSH_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bbox_msg_reader;

    localparam int          c_POLL_INTERVAL = 16;
    localparam int          c_READ_LATENCY  = 1;
    localparam logic [31:0] c_MSG_ID        = 32'h0052_4242;
    localparam int          c_BUDGET        = 3000;

    typedef struct packed {
        logic [10:0] x_min;
        logic [10:0] y_min;
        logic [10:0] x_max;
        logic [10:0] y_max;
    } box_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m_chipselect;
    logic        m_read;
    logic        m_write;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [10:0] out_x_min;
    logic [10:0] out_y_min;
    logic [10:0] out_x_max;
    logic [10:0] out_y_max;
    logic [7:0]  sync_err_count;

    always #5 clk = ~clk;

    bbox_msg_reader #(
        .POLL_INTERVAL (c_POLL_INTERVAL),
        .READ_LATENCY  (c_READ_LATENCY),
        .MSG_ID        (c_MSG_ID)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .m_chipselect   (m_chipselect),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_address      (m_address),
        .m_writedata    (m_writedata),
        .m_readdata     (m_readdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_x_min      (out_x_min),
        .out_y_min      (out_y_min),
        .out_x_max      (out_x_max),
        .out_y_max      (out_y_max),
        .sync_err_count (sync_err_count)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          status_reads = 0;
    int          msg_reads = 0;
    int          writes = 0;
    int          last_poll = 0;
    int          prev_poll = 0;
    int          valid_rise = 0;
    logic        prev_valid = 1'b0;
    logic        after_write = 1'b0;
    int          ready_mode = 1;

    logic [31:0] fifo[$];
    logic [31:0] stream[$];
    int          sp = 0;
    box_t        exp_q[$];
    int          exp_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic box_t decode(input logic [31:0] a, input logic [31:0] b);
        box_t r;
        r.x_min = a[26:16];
        r.y_min = a[10:0];
        r.x_max = b[26:16];
        r.y_max = b[10:0];
        return r;
    endfunction

    task automatic push_word(input logic [31:0] w);
        stream.push_back(w);
        fifo.push_back(w);
    endtask

    // Walk the word stream: a matching header consumes three words and yields a
    // box; any other word counts as a sync error.
    task automatic model_scan();
        while (stream.size() - sp >= 3) begin
            if (stream[sp] == c_MSG_ID) begin
                exp_q.push_back(decode(stream[sp+1], stream[sp+2]));
                sp += 3;
            end else begin
                if (exp_err < 255) exp_err++;
`ifdef BBOX_READER_FLUSH_EN
                sp = stream.size();
`else
                sp++;
`endif
            end
        end
    endtask

    // Message-port slave with registered read data.
    always @(posedge clk) begin
        logic [31:0] junk;
        logic [7:0]  cnt;
        junk = $urandom();
        cnt  = (fifo.size() > 255) ? 8'hFF : 8'(fifo.size());
        if (m_read) begin
            if (m_address == 3'd0)
                m_readdata <= {junk[31:16], cnt, junk[7:0]};
            else if (m_address == 3'd1 && fifo.size() > 0)
                m_readdata <= fifo.pop_front();
            else
                m_readdata <= junk;
        end
        if (m_write && m_address == 3'd0 && m_writedata[4]) fifo.delete();
    end

    // Compare process and bus monitor.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            check("chipselect", m_chipselect, m_read | m_write);
            check("rw_exclusive", m_read & m_write, 1'b0);
`ifndef BBOX_READER_FLUSH_EN
            check("no_write", m_write, 1'b0);
`endif
            if (m_read) begin
                if (after_write) check("poll_after_flush", m_address, 3'd0);
                after_write <= 1'b0;
                if (m_address == 3'd0) begin
                    status_reads <= status_reads + 1;
                    prev_poll    <= last_poll;
                    last_poll    <= cyc;
                end else if (m_address == 3'd1) begin
                    msg_reads <= msg_reads + 1;
                end
            end
            if (m_write) begin
                writes      <= writes + 1;
                after_write <= 1'b1;
                check("flush_addr", m_address, 3'd0);
                check("flush_data", m_writedata, 32'h10);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_box: actual=%0h required=none",
                             {out_x_min, out_y_min, out_x_max, out_y_max});
                end else begin
                    check("box", {out_x_min, out_y_min, out_x_max, out_y_max}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
                if (!prev_valid) valid_rise <= cyc;
            end
            prev_valid <= out_valid;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!out_valid && t < c_BUDGET) begin
            tick();
            t++;
        end
        check({name, "_valid_timeout"}, t < c_BUDGET, 1'b1);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((fifo.size() != stream.size() - sp || exp_q.size() != 0 || out_valid) && t < c_BUDGET) begin
            tick();
            t++;
        end
        repeat (6) tick();
        check({name, "_drain_timeout"}, t < c_BUDGET, 1'b1);
        check({name, "_sync_err"}, sync_err_count, exp_err);
    endtask

    initial begin
        int t;
        int lat;
        int reads0;
        int base;

        repeat (3) @(posedge clk);
        #2;
        check("rst_read", m_read, 1'b0);
        check("rst_cs", m_chipselect, 1'b0);
        check("rst_write", m_write, 1'b0);
        check("rst_addr", m_address, 3'd0);
        check("rst_wdata", m_writedata, 32'd0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_coords", {out_x_min, out_y_min, out_x_max, out_y_max}, 44'd0);
        check("rst_err", sync_err_count, 8'd0);
        reset = 1'b0;

        // Empty FIFO: polls spaced POLL_INTERVAL + 2 apart, no message reads.
        t = 0;
        while (status_reads < 3 && t < 200) begin tick(); t++; end
        check("idle_timeout", status_reads >= 3, 1'b1);
        check("idle_spacing", last_poll - prev_poll, 18);
        check("idle_no_msg", msg_reads, 0);

        // Best-case latency and decode.
        push_word(c_MSG_ID);
        push_word(32'h0010_0020);
        push_word(32'h0050_0060);
        model_scan();
        wait_valid("basic");
        check("basic_box", {out_x_min, out_y_min, out_x_max, out_y_max},
              {11'd16, 11'd32, 11'd80, 11'd96});
        tick();
        lat = valid_rise - last_poll;
        check("basic_latency", lat, 8);
        tick();
        check("basic_repoll", last_poll - valid_rise, 1);
        drain("basic");

        // Bad header followed by a good message.
`ifdef BBOX_READER_FLUSH_EN
        push_word(32'hDEAD_BEEF);
        push_word(32'h0);
        push_word(32'h0);
        model_scan();
        drain("flush");
        check("flush_writes", writes, 1);
`else
        push_word(32'hDEAD_BEEF);
`endif
        push_word(c_MSG_ID);
        push_word(32'hF923_F456);
        push_word(32'h0789_07FF);
        model_scan();
        wait_valid("resync");
        check("resync_box", {out_x_min, out_y_min, out_x_max, out_y_max},
              {11'd291, 11'd1110, 11'd1929, 11'd2047});
        drain("resync");
        check("resync_err", sync_err_count, 8'd1);

        // Downstream stall.
        ready_mode = 0;
        push_word(c_MSG_ID);
        push_word(32'h0001_0002);
        push_word(32'h0003_0004);
        model_scan();
        wait_valid("stall");
        reads0 = status_reads + msg_reads;
        repeat (50) tick();
        check("stall_valid", out_valid, 1'b1);
        check("stall_bus", status_reads + msg_reads, reads0);
        check("stall_box", {out_x_min, out_y_min, out_x_max, out_y_max},
              {11'd1, 11'd2, 11'd3, 11'd4});
        ready_mode = 1;
        tick();
        tick();
        check("stall_accept", out_valid, 1'b0);
        drain("stall");

        // Random traffic with occasional corrupt headers and stray words.
        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            int nmsg;
            nmsg = $urandom_range(1, 4);
            for (int m = 0; m < nmsg; m++) begin
                if ($urandom_range(0, 4) == 0) push_word($urandom());
                push_word(($urandom_range(0, 5) == 0) ? $urandom() : c_MSG_ID);
                push_word($urandom());
                push_word($urandom());
            end
            model_scan();
            drain("rand");
        end

        // Reset in W1_WAIT abandons the message.
        ready_mode = 1;
        fifo.delete();
        stream.delete();
        sp = 0;
        base = msg_reads;
        fifo.push_back(c_MSG_ID);
        fifo.push_back(32'h0011_0022);
        fifo.push_back(32'h0033_0044);
        t = 0;
        while (msg_reads < base + 2 && t < 200) begin tick(); t++; end
        check("rstmid_reach_w1", t < 200, 1'b1);
        reset = 1'b1;
        tick();
        check("rstmid_valid", out_valid, 1'b0);
        check("rstmid_read", m_read, 1'b0);
        check("rstmid_err", sync_err_count, 8'd0);
        fifo.delete();
        exp_err = 0;
        reset = 1'b0;
        t = 0;
        while (!m_read && t < 10) begin tick(); t++; end
        check("rstmid_restart", m_read, 1'b1);
        check("rstmid_poll_addr", m_address, 3'd0);
        drain("rstmid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
